// File: rtl/picorv32_mem_arbiter.sv
// Two-master (CPU / vector coprocessor) arbiter in front of a single
// picorv32-style memory port. Round-robin on ties, one transaction in
// flight, registered memory request, sticky wait-timeout flag.
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,  // must be >= 1
  parameter bit          RESET_LAST_VEC = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  // CPU master
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  // vector-coprocessor master
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  // shared memory port
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  // status
  output logic        grant_vec,
  output logic        mem_timeout
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] WMAX  = WCW'(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0] WMAX1 = WCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_VEC} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last_vec;
  logic [WCW-1:0]  r_wait;
  logic [31:0]     r_cpu_rdata, r_vec_rdata;
  logic            w_gnt_cpu, w_gnt_vec, w_busy, w_wait_inc;

  assign w_busy     = (r_state != IDLE);
  assign w_wait_inc = w_busy && !mem_ready && (r_wait != WMAX);

  // Next-state: grant decision in IDLE, release on mem_ready in GNT_x
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_cpu   = 1'b0;
    w_gnt_vec   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_mem_valid && vec_mem_valid) begin
          // tie: whoever was not served last wins
          w_gnt_cpu = r_last_vec;
          w_gnt_vec = !r_last_vec;
        end else begin
          w_gnt_cpu = cpu_mem_valid;
          w_gnt_vec = vec_mem_valid;
        end
        if (w_gnt_cpu)      w_state_nxt = GNT_CPU;
        else if (w_gnt_vec) w_state_nxt = GNT_VEC;
      end
      GNT_CPU, GNT_VEC: if (mem_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, round-robin history and the registered memory request
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_last_vec <= RESET_LAST_VEC;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_cpu) begin
        r_last_vec <= 1'b0;
        mem_valid  <= 1'b1;
        mem_instr  <= cpu_mem_instr;
        mem_addr   <= cpu_mem_addr;
        mem_wdata  <= cpu_mem_wdata;
        mem_wstrb  <= cpu_mem_wstrb;
      end else if (w_gnt_vec) begin
        r_last_vec <= 1'b1;
        mem_valid  <= 1'b1;
        mem_instr  <= 1'b0;
        mem_addr   <= vec_mem_addr;
        mem_wdata  <= vec_mem_wdata;
        mem_wstrb  <= vec_mem_wstrb;
      end else if (w_busy && mem_ready) begin
        mem_valid  <= 1'b0;
      end
    end
  end

  // Wait counter and sticky timeout; the transaction is never aborted
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wait      <= '0;
      mem_timeout <= 1'b0;
    end else if (w_gnt_cpu || w_gnt_vec) begin
      r_wait <= '0;
    end else if (w_wait_inc) begin
      r_wait <= r_wait + 1'b1;
      if (r_wait == WMAX1) mem_timeout <= 1'b1;
    end
  end

  // Remember the last word delivered to each master
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cpu_rdata <= '0;
      r_vec_rdata <= '0;
    end else if (mem_ready) begin
      if (r_state == GNT_CPU) r_cpu_rdata <= mem_rdata;
      if (r_state == GNT_VEC) r_vec_rdata <= mem_rdata;
    end
  end

  // Ready is gated by resetn so a transaction abandoned by reset never completes
  assign cpu_mem_ready = resetn && (r_state == GNT_CPU) && mem_ready;
  assign vec_mem_ready = resetn && (r_state == GNT_VEC) && mem_ready;
  assign cpu_mem_rdata = (r_state == GNT_CPU) ? mem_rdata : r_cpu_rdata;
  assign vec_mem_rdata = (r_state == GNT_VEC) ? mem_rdata : r_vec_rdata;
  assign grant_vec     = (r_state == GNT_VEC);

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: transaction-level round-robin model,
// responder memory with random latency, directed corner scenarios.
module tb_picorv32_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_mem_valid, cpu_mem_instr;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr, vec_mem_wdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic [31:0] vec_mem_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        grant_vec, mem_timeout;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.TIMEOUT_CYCLES(TO), .RESET_LAST_VEC(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
    .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
    .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
    .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .grant_vec(grant_vec), .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } txn_t;

  typedef struct {
    bit          is_vec;
    txn_t        t;
    logic [31:0] rdata;
  } exp_t;

  int          vectors = 0, miscompares = 0;
  logic [31:0] mem     [256];   // memory behind the port
  logic [31:0] ref_mem [256];   // model's view of the same memory
  txn_t        cpu_q[$], vec_q[$];
  logic [31:0] last_cpu_rd, last_vec_rd;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.addr  = 32'($urandom_range(15, 0)) << 2;
    t.wdata = $urandom;
    t.wstrb = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom);
    t.instr = 1'($urandom);
    return t;
  endfunction

  task automatic drive_cpu(input logic v, input txn_t t);
    cpu_mem_valid = v; cpu_mem_addr = t.addr; cpu_mem_wdata = t.wdata;
    cpu_mem_wstrb = t.wstrb; cpu_mem_instr = t.instr;
  endtask

  task automatic drive_vec(input logic v, input txn_t t);
    vec_mem_valid = v; vec_mem_addr = t.addr; vec_mem_wdata = t.wdata;
    vec_mem_wstrb = t.wstrb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; cpu_mem_valid = 1'b0; vec_mem_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1; last_cpu_rd = '0; last_vec_rd = '0;
  endtask

  // Both masters keep a request up while their queue is non-empty; the
  // expected service order follows the round-robin rule at transaction level.
  task automatic run_engine(input int lat_min, input int lat_max, input string tag,
                            output int first_grant);
    exp_t eq[$];
    exp_t e;
    int ci, vi, nc, nv, gi, cdone, vdone, wcnt, lat, budget;
    bit last, pick, pv, in_gnt, cur_vec, ecr, evr;
    logic [7:0] idx;
    nc = cpu_q.size(); nv = vec_q.size();
    ci = 0; vi = 0; last = 1'b0;
    while (ci < nc || vi < nv) begin
      pick = (vi < nv) && ((ci >= nc) || !last);
      e.is_vec = pick;
      if (pick) begin e.t = vec_q[vi]; e.t.instr = 1'b0; vi++; end
      else begin e.t = cpu_q[ci]; ci++; end
      idx = e.t.addr[9:2];
      e.rdata = ref_mem[idx];
      ref_mem[idx] = merge(ref_mem[idx], e.t.wdata, e.t.wstrb);
      eq.push_back(e);
      last = pick;
    end
    ci = 0; vi = 0; gi = 0; cdone = 0; vdone = 0; pv = 0; in_gnt = 0; cur_vec = 0;
    wcnt = 0; first_grant = -1; e = eq[0];
    lat = $urandom_range(lat_max, lat_min);
    if (nc > 0) drive_cpu(1'b1, cpu_q[0]); else cpu_mem_valid = 1'b0;
    if (nv > 0) drive_vec(1'b1, vec_q[0]); else vec_mem_valid = 1'b0;
    budget = (nc + nv) * (lat_max + 3) + 10;
    for (int cyc = 0; cyc < budget && (cdone < nc || vdone < nv); cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        if (wcnt >= lat) begin
          idx = mem_addr[9:2];
          mem_ready = 1'b1; mem_rdata = mem[idx];
          mem[idx] = merge(mem[idx], mem_wdata, mem_wstrb);
          wcnt = 0; lat = $urandom_range(lat_max, lat_min);
        end else begin
          wcnt++; mem_ready = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        wcnt = 0; mem_ready = 1'b0; mem_rdata = $urandom;
      end
      #1;
      if (mem_valid && !pv) begin
        if (first_grant < 0) first_grant = cyc;
        vectors++;
        if (gi >= eq.size()) begin
          miscompares++;
          $display("FAIL %s extra_grant: got vec=%0b addr=%h, required no further grant",
                   tag, grant_vec, mem_addr);
        end else begin
          e = eq[gi]; gi++; in_gnt = 1; cur_vec = e.is_vec;
        end
      end
      pv = mem_valid;
      vectors++;
      if ({mem_valid, grant_vec} !== {in_gnt, in_gnt & cur_vec} ||
          (in_gnt && {mem_addr, mem_wdata, mem_wstrb, mem_instr} !== e.t)) begin
        miscompares++;
        $display("FAIL %s grant[%0d]: got v=%0b gv=%0b a=%h d=%h s=%h i=%0b, required v=%0b gv=%0b a=%h d=%h s=%h i=%0b",
                 tag, gi - 1, mem_valid, grant_vec, mem_addr, mem_wdata, mem_wstrb, mem_instr,
                 in_gnt, in_gnt & cur_vec, e.t.addr, e.t.wdata, e.t.wstrb, e.t.instr);
      end
      ecr = in_gnt && !cur_vec && mem_ready;
      evr = in_gnt && cur_vec && mem_ready;
      vectors++;
      if ({cpu_mem_ready, vec_mem_ready} !== {ecr, evr}) begin
        miscompares++;
        $display("FAIL %s ready: got cpu=%0b vec=%0b, required cpu=%0b vec=%0b",
                 tag, cpu_mem_ready, vec_mem_ready, ecr, evr);
      end
      vectors++;
      if ((!(in_gnt && !cur_vec) && cpu_mem_rdata !== last_cpu_rd) ||
          (!(in_gnt && cur_vec) && vec_mem_rdata !== last_vec_rd)) begin
        miscompares++;
        $display("FAIL %s rdata_hold: got cpu=%h vec=%h, required cpu=%h vec=%h",
                 tag, cpu_mem_rdata, vec_mem_rdata, last_cpu_rd, last_vec_rd);
      end
      if (ecr || evr) begin
        vectors++;
        if ((ecr ? cpu_mem_rdata : vec_mem_rdata) !== e.rdata) begin
          miscompares++;
          $display("FAIL %s rdata[%0d]: got %h, required %h", tag, gi - 1,
                   ecr ? cpu_mem_rdata : vec_mem_rdata, e.rdata);
        end
        in_gnt = 0;
        if (ecr) begin
          last_cpu_rd = e.rdata; cdone++; ci++;
          if (ci < nc) drive_cpu(1'b1, cpu_q[ci]); else cpu_mem_valid = 1'b0;
        end else begin
          last_vec_rd = e.rdata; vdone++; vi++;
          if (vi < nv) drive_vec(1'b1, vec_q[vi]); else vec_mem_valid = 1'b0;
        end
      end
    end
    vectors++;
    if (cdone < nc || vdone < nv) begin
      miscompares++;
      $display("FAIL %s cycle_budget: got cpu %0d/%0d vec %0d/%0d done", tag, cdone, nc, vdone, nv);
    end
    @(negedge clk);
    mem_ready = 1'b0; cpu_mem_valid = 1'b0; vec_mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, grant_vec, mem_timeout,
         cpu_mem_ready, vec_mem_ready, cpu_mem_rdata, vec_mem_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%0b a=%h d=%h s=%h gv=%0b to=%0b crd=%h vrd=%h, required all 0",
               mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_vec, mem_timeout,
               cpu_mem_rdata, vec_mem_rdata);
    end
    resetn = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: got mem_valid=%0b, required 0", mem_valid);
    end
  endtask

  task automatic test_cpu_read();
    int fg;
    do_reset();
    cpu_q = {}; vec_q = {};
    cpu_q.push_back('{addr: 32'h190, wdata: 32'h0, wstrb: 4'h0, instr: 1'b1});
    run_engine(1, 1, "cpu_read", fg);
    vectors++;
    if (fg !== 0) begin
      miscompares++;
      $display("FAIL cpu_read_latency: got grant after %0d extra cycles, required 0", fg);
    end
    #1;
    vectors++;
    if (cpu_mem_rdata !== 32'h04030201) begin
      miscompares++;
      $display("FAIL cpu_read_data: got %h, required 04030201", cpu_mem_rdata);
    end
  endtask

  task automatic test_vec_write();
    int fg;
    do_reset();
    cpu_q = {}; vec_q = {};
    vec_q.push_back('{addr: 32'h258, wdata: 32'h0000000A, wstrb: 4'hF, instr: 1'b0});
    run_engine(0, 2, "vec_write", fg);
    vectors++;
    if (mem[150] !== 32'h0000000A) begin
      miscompares++;
      $display("FAIL vec_write_mem: got word150=%h, required 0000000a", mem[150]);
    end
  endtask

  task automatic test_simultaneous();
    int fg;
    do_reset();
    cpu_q = {}; vec_q = {};
    cpu_q.push_back(rnd_txn());
    vec_q.push_back(rnd_txn());
    run_engine(0, 1, "simultaneous", fg);
  endtask

  task automatic test_fairness();
    int fg;
    do_reset();
    cpu_q = {}; vec_q = {};
    for (int i = 0; i < 8; i++) begin cpu_q.push_back(rnd_txn()); vec_q.push_back(rnd_txn()); end
    run_engine(0, 0, "fairness", fg);
  endtask

  task automatic test_random();
    int fg, nc, nv;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      cpu_q = {}; vec_q = {};
      nc = $urandom_range(8, 0); nv = $urandom_range(8, 1);
      for (int i = 0; i < nc; i++) cpu_q.push_back(rnd_txn());
      for (int i = 0; i < nv; i++) vec_q.push_back(rnd_txn());
      run_engine(0, 2, "random", fg);
    end
  endtask

  task automatic test_idle_ready();
    do_reset();
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    vectors++;
    if (cpu_mem_ready !== 1'b0 || vec_mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready_pulse: got cpu=%0b vec=%0b, required 0 0", cpu_mem_ready, vec_mem_ready);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    vectors++;
    if (mem_valid !== 1'b0 || grant_vec !== 1'b0 || cpu_mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL idle_ready_state: got v=%0b gv=%0b crd=%h, required 0 0 0",
               mem_valid, grant_vec, cpu_mem_rdata);
    end
  endtask

  task automatic test_drop();
    txn_t ta, tc;
    ta = '{addr: 32'h10, wdata: 32'h0, wstrb: 4'h0, instr: 1'b0};
    tc = '{addr: 32'h20, wdata: 32'h0, wstrb: 4'h0, instr: 1'b1};
    do_reset();
    drive_vec(1'b1, ta);
    @(negedge clk); #1;
    drive_cpu(1'b1, tc);
    @(negedge clk); cpu_mem_valid = 1'b0;
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h5A5A0001; #1;
    vectors++;
    if (vec_mem_ready !== 1'b1 || cpu_mem_ready !== 1'b0 || vec_mem_rdata !== 32'h5A5A0001) begin
      miscompares++;
      $display("FAIL drop_vec_done: got vr=%0b cr=%0b vrd=%h, required 1 0 5a5a0001",
               vec_mem_ready, cpu_mem_ready, vec_mem_rdata);
    end
    vec_mem_valid = 1'b0;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_no_phantom: got mem_valid=%0b, required 0", mem_valid);
    end
    drive_cpu(1'b1, tc); drive_vec(1'b1, ta);
    @(negedge clk); #1;
    vectors++;
    if (mem_valid !== 1'b1 || grant_vec !== 1'b0 || mem_addr !== 32'h20 || mem_instr !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_rr_cpu_wins: got v=%0b gv=%0b a=%h i=%0b, required 1 0 00000020 1",
               mem_valid, grant_vec, mem_addr, mem_instr);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    cpu_mem_valid = 1'b0; vec_mem_valid = 1'b0;
    @(negedge clk); mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    txn_t t;
    t = '{addr: 32'h80, wdata: 32'h0, wstrb: 4'h0, instr: 1'b0};
    do_reset();
    drive_cpu(1'b1, t);
    @(negedge clk); #1;
    vectors++;
    if (mem_valid !== 1'b1 || grant_vec !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_grant: got v=%0b gv=%0b, required 1 0", mem_valid, grant_vec);
    end
    @(negedge clk); resetn = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11111111; #1;
    vectors++;
    if (cpu_mem_ready !== 1'b0 || vec_mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_no_ready: got cpu=%0b vec=%0b, required 0 0", cpu_mem_ready, vec_mem_ready);
    end
    @(negedge clk); resetn = 1'b1; mem_ready = 1'b0; #1;
    vectors++;
    if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || cpu_mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_cleared: got v=%0b a=%h crd=%h, required 0 0 0",
               mem_valid, mem_addr, cpu_mem_rdata);
    end
    @(negedge clk); #1;
    vectors++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h80) begin
      miscompares++;
      $display("FAIL rstmid_regrant: got v=%0b a=%h, required 1 00000080", mem_valid, mem_addr);
    end
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h22222222; #1;
    vectors++;
    if (cpu_mem_ready !== 1'b1 || cpu_mem_rdata !== 32'h22222222) begin
      miscompares++;
      $display("FAIL rstmid_complete: got r=%0b d=%h, required 1 22222222", cpu_mem_ready, cpu_mem_rdata);
    end
    cpu_mem_valid = 1'b0;
    @(negedge clk); mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    txn_t t;
    bit   exp_to;
    t = '{addr: 32'h40, wdata: 32'h0, wstrb: 4'h0, instr: 1'b1};
    do_reset();
    drive_cpu(1'b1, t);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      mem_ready = (k == 7); mem_rdata = 32'hCAFE0000 + 32'(k);
      if (k >= 2 && k <= 6) cpu_mem_addr = $urandom;
      #1;
      exp_to = (k - 1 >= TO);
      vectors++;
      if (mem_timeout !== exp_to) begin
        miscompares++;
        $display("FAIL timeout_flag[k=%0d]: got %0b, required %0b", k, mem_timeout, exp_to);
      end
      if (k <= 7) begin
        vectors++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h40) begin
          miscompares++;
          $display("FAIL timeout_hold[k=%0d]: got v=%0b a=%h, required 1 00000040", k, mem_valid, mem_addr);
        end
      end
      vectors++;
      if (cpu_mem_ready !== (k == 7)) begin
        miscompares++;
        $display("FAIL timeout_ready[k=%0d]: got %0b, required %0b", k, cpu_mem_ready, k == 7);
      end
      if (k == 7) cpu_mem_valid = 1'b0;
    end
    do_reset();
    #1;
    vectors++;
    if (mem_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_reset_clear: got %0b, required 0", mem_timeout);
    end
  endtask

  initial begin
    resetn = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    cpu_mem_valid = 1'b0; cpu_mem_instr = 1'b0; cpu_mem_addr = '0;
    cpu_mem_wdata = '0; cpu_mem_wstrb = '0;
    vec_mem_valid = 1'b0; vec_mem_addr = '0; vec_mem_wdata = '0; vec_mem_wstrb = '0;
    last_cpu_rd = '0; last_vec_rd = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[100] = 32'h04030201; ref_mem[100] = 32'h04030201;
    test_reset();
    test_cpu_read();
    test_vec_write();
    test_simultaneous();
    test_fairness();
    test_idle_ready();
    test_drop();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
PICORV32_MEM_ARBITER -- requirements
Module: picorv32_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles a granted transaction may wait for mem_ready before mem_timeout is set.
REQ-002 Parameter RESET_LAST_VEC, default 0: initial round-robin history; 0 means last grant was CPU, so VEC wins the first tie.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 cpu_mem_valid  input  1  CPU request, held high until cpu_mem_ready.
REQ-006 cpu_mem_instr  input  1  CPU fetch qualifier.
REQ-007 cpu_mem_addr / cpu_mem_wdata  input  32 / 32  CPU address and write data.
REQ-008 cpu_mem_wstrb  input  4  CPU byte strobes; 0000 = read.
REQ-009 cpu_mem_ready  output  1  CPU transaction complete.
REQ-010 cpu_mem_rdata  output  32  CPU read data.
REQ-011 vec_mem_valid, vec_mem_addr, vec_mem_wdata, vec_mem_wstrb  input  1/32/32/4  vector-coprocessor request, same protocol as CPU.
REQ-012 vec_mem_ready / vec_mem_rdata  output  1 / 32  vector-coprocessor completion and read data.
REQ-013 mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb  output  1/1/32/32/4  shared memory request, all registered.
REQ-014 mem_ready / mem_rdata  input  1 / 32  memory one-cycle completion pulse and read data.
REQ-015 grant_vec  output  1  high while the VEC master owns the memory port.
REQ-016 mem_timeout  output  1  sticky flag; a granted transaction exceeded TIMEOUT_CYCLES.

Function
REQ-017 State machine states: IDLE, GNT_CPU, GNT_VEC.
REQ-018 In IDLE with only cpu_mem_valid high: next state is GNT_CPU.
REQ-019 In IDLE with only vec_mem_valid high: next state is GNT_VEC.
REQ-020 In IDLE with both requests high: grant the master not granted last (round-robin); update the last-grant register on every grant.
REQ-021 In IDLE with no request: stay in IDLE; mem_valid stays 0.
REQ-022 On entry to GNT_x, latch the granted master's addr, wdata, wstrb and instr (instr = 0 for VEC) into the mem_* registers, and set mem_valid = 1 in the same edge. Latency from request in IDLE to mem_valid: 1 cycle.
REQ-023 While in GNT_x, mem_* request outputs are held constant; master input changes are ignored.
REQ-024 In GNT_x, x_mem_ready = mem_ready combinationally, and x_mem_rdata = mem_rdata; the other master's ready = 0.
REQ-025 In GNT_x with mem_ready = 1: clear mem_valid and return to IDLE at that edge. One idle bubble cycle precedes the next grant.
REQ-026 x_mem_rdata for a non-granted master holds its last delivered value.
REQ-027 grant_vec = 1 exactly in GNT_VEC.
REQ-028 A wait counter clears on each grant and increments each cycle in GNT_x without mem_ready. Count saturates at TIMEOUT_CYCLES.
REQ-029 When the wait counter reaches TIMEOUT_CYCLES, set mem_timeout. The arbiter keeps waiting (no abort). mem_timeout clears only on reset.
REQ-030 mem_ready while in IDLE is ignored: no master ready pulse and no state change.
REQ-031 A master dropping valid while not granted loses its pending request; no request is recorded.

Reset
REQ-032 With resetn = 0 at a rising edge: state = IDLE, mem_valid = 0, mem_instr = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0, wait counter = 0, mem_timeout = 0, last-grant = RESET_LAST_VEC.
REQ-033 Reset during GNT_x abandons the transaction; no ready pulse to either master.
REQ-034 cpu_mem_rdata and vec_mem_rdata reset to 0.
REQ-035 Outputs are driven to reset values from the first edge with resetn = 0.

Verification
REQ-036 CPU-only read: CPU read, addr 0x190 with memory word 0x04030201, memory ready one cycle after valid -> mem_valid one cycle after request; cpu_mem_ready pulses once with rdata 0x04030201; vec_mem_ready stays 0.
REQ-037 VEC-only write: VEC write, addr 0x258, wdata 0x0000000A, wstrb 1111 -> mem_wstrb = 1111; grant_vec = 1 until mem_ready; memory word 150 = 0x0000000A.
REQ-038 Simultaneous requests: CPU and VEC request in the same cycle after reset (RESET_LAST_VEC = 0) -> VEC served first; CPU served after one bubble; both ready pulses occur exactly once.
REQ-039 Stream fairness: both masters request back-to-back for 8 transactions -> grants strictly alternate CPU/VEC; no master waits more than one transaction.
REQ-040 Timeout: TIMEOUT_CYCLES = 4, mem_ready withheld 6 cycles -> mem_timeout rises after 4 waiting cycles and stays high after the eventual mem_ready.
REQ-041 Reset mid-transaction: resetn = 0 while in GNT_CPU -> next edge mem_valid = 0, no cpu_mem_ready; after reset release, the pending CPU request is granted normally.
